// File: rtl/smpl_iter.sv
// smpl_iter: walks a triangle's bounding box on the subsample grid, one candidate sample per cycle.
// Upstream is stalled through halt_RnnnnL while a triangle is being iterated.
module smpl_iter #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] color_R13U [COLORS],
  input  logic signed [SIGFIG-1:0] box_R13S [2][2],
  input  logic                     validTri_R13H,
  input  logic        [3:0]        subSample_RnnnnU,
  output logic                     halt_RnnnnL,
  output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
  output logic        [SIGFIG-1:0] color_R14U [COLORS],
  output logic signed [SIGFIG-1:0] sample_R14S [2],
  output logic                     validSamp_R14H
);
  typedef enum logic {WAIT_STATE, TEST_STATE} state_t;
  state_t                   r_state;
  logic signed [SIGFIG-1:0] r_llx, r_urx, r_ury;
  logic        [SIGFIG-1:0] r_step;
  logic        [1:0]        w_lg2;
  logic signed [SIGFIG:0]   w_nx, w_ny, w_urx, w_ury;
  always_comb w_lg2 = (subSample_RnnnnU == 4'b0001) ? 2'd3 :
                      (subSample_RnnnnU == 4'b0010) ? 2'd2 :
                      (subSample_RnnnnU == 4'b0100) ? 2'd1 : 2'd0;
  // One extra bit keeps the next-step comparisons exact at the top of the range
  assign w_nx  = {sample_R14S[0][SIGFIG-1], sample_R14S[0]} + {1'b0, r_step};
  assign w_ny  = {sample_R14S[1][SIGFIG-1], sample_R14S[1]} + {1'b0, r_step};
  assign w_urx = {r_urx[SIGFIG-1], r_urx};
  assign w_ury = {r_ury[SIGFIG-1], r_ury};
  assign halt_RnnnnL = (r_state == WAIT_STATE);
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= WAIT_STATE;
      validSamp_R14H <= 1'b0;
      tri_R14S       <= '{default: '{default: '0}};
      color_R14U     <= '{default: '0};
      sample_R14S    <= '{default: '0};
      r_llx          <= '0;
      r_urx          <= '0;
      r_ury          <= '0;
      r_step         <= '0;
    end else if (r_state == WAIT_STATE) begin
      validSamp_R14H <= 1'b0;
      if (validTri_R13H) begin
        r_state        <= TEST_STATE;
        validSamp_R14H <= 1'b1;
        tri_R14S       <= tri_R13S;
        color_R14U     <= color_R13U;
        sample_R14S[0] <= box_R13S[0][0];
        sample_R14S[1] <= box_R13S[0][1];
        r_llx          <= box_R13S[0][0];
        r_urx          <= box_R13S[1][0];
        r_ury          <= box_R13S[1][1];
        r_step         <= SIGFIG'(1) << (RADIX - int'(w_lg2));
      end
    end else if (w_nx <= w_urx) begin
      sample_R14S[0] <= w_nx[SIGFIG-1:0];
    end else if (w_ny <= w_ury) begin
      sample_R14S[0] <= r_llx;
      sample_R14S[1] <= w_ny[SIGFIG-1:0];
    end else begin
      r_state        <= WAIT_STATE;
      validSamp_R14H <= 1'b0;
    end
  end
endmodule

// File: tb/tb_smpl_iter.sv
// tb_smpl_iter: scoreboard bench for smpl_iter; a raster-order model queues expected samples per triangle.
module tb_smpl_iter;
  localparam int SF = 24;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signed [SF-1:0] tri_in [3][3];
  logic signed [SF-1:0] tri_out [3][3];
  logic        [SF-1:0] col_in [3];
  logic        [SF-1:0] col_out [3];
  logic signed [SF-1:0] box [2][2];
  logic signed [SF-1:0] samp [2];
  logic       valid_tri = 1'b0;
  logic [3:0] ss = 4'b1000;
  logic       halt, vsamp;
  typedef struct {int x; int y; int tag;} exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  smpl_iter dut (
    .clk(clk), .rst(rst), .tri_R13S(tri_in), .color_R13U(col_in), .box_R13S(box),
    .validTri_R13H(valid_tri), .subSample_RnnnnU(ss), .halt_RnnnnL(halt),
    .tri_R14S(tri_out), .color_R14U(col_out), .sample_R14S(samp), .validSamp_R14H(vsamp)
  );

  always #5 clk = ~clk;

  function automatic int step_of(logic [3:0] s);
    return s == 4'b0001 ? 128 : s == 4'b0010 ? 256 : s == 4'b0100 ? 512 : 1024;
  endfunction

  function automatic bit outs_zero();
    bit z = (samp[0] == 0) && (samp[1] == 0);
    for (int v = 0; v < 3; v++) begin
      z &= (col_out[v] == 0);
      for (int a = 0; a < 3; a++) z &= (tri_out[v][a] == 0);
    end
    return z;
  endfunction

  task automatic load(input int llx, input int lly, input int urx, input int ury,
                      input logic [3:0] s, input int tag, output int n);
    int st = step_of(s);
    box[0][0] = SF'(llx); box[0][1] = SF'(lly);
    box[1][0] = SF'(urx); box[1][1] = SF'(ury);
    ss = s;
    for (int v = 0; v < 3; v++) begin
      col_in[v] = SF'(tag + 1);
      for (int a = 0; a < 3; a++) tri_in[v][a] = SF'(tag);
    end
    n = 0;
    for (int y = lly; y <= ury; y += st)
      for (int x = llx; x <= urx; x += st) begin
        q.push_back('{x, y, tag});
        n++;
      end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (vsamp === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_sample: got (%0d,%0d), required no sample", int'(samp[0]), int'(samp[1]));
        end else begin
          e = q.pop_front();
          if (int'(samp[0]) !== e.x || int'(samp[1]) !== e.y || int'(tri_out[2][1]) !== e.tag
              || int'(col_out[2]) !== e.tag + 1) begin
            errors++;
            $display("FAIL sample: got (%0d,%0d) tri=%0d col=%0d, required (%0d,%0d) tri=%0d col=%0d",
                     int'(samp[0]), int'(samp[1]), int'(tri_out[2][1]), int'(col_out[2]),
                     e.x, e.y, e.tag, e.tag + 1);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (vsamp !== 1'b0 || halt !== 1'b1 || !outs_zero()) begin
      errors++;
      $display("FAIL reset: valid=%b halt=%b zero=%b, required valid=0 halt=1 zero=1", vsamp, halt, outs_zero());
    end
    rst = 1'b1;
  endtask

  task automatic run_tri(input int llx, input int lly, input int urx, input int ury,
                         input logic [3:0] s, input logic [3:0] mid_ss, input int tag);
    int n;
    @(negedge clk);
    load(llx, lly, urx, ury, s, tag, n);
    valid_tri = 1'b1;
    @(negedge clk);
    valid_tri = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == 1) ss = mid_ss;
      checks++;
      if (vsamp !== 1'b1 || halt !== 1'b0) begin
        errors++;
        $display("FAIL iterate tag=%0d cycle=%0d: valid=%b halt=%b, required valid=1 halt=0", tag, i, vsamp, halt);
      end
      @(negedge clk);
    end
    checks++;
    if (vsamp !== 1'b0 || halt !== 1'b1 || q.size() != 0) begin
      errors++;
      $display("FAIL end tag=%0d: valid=%b halt=%b left=%0d, required valid=0 halt=1 left=0", tag, vsamp, halt, q.size());
    end
    q.delete();
  endtask

  task automatic test_basic();
    run_tri(0, 0, 1024, 1024, 4'b1000, 4'b1000, 10);
  endtask

  task automatic test_step_latch();
    run_tri(0, 0, 1024, 1024, 4'b0100, 4'b1000, 20);
  endtask

  task automatic test_degenerate();
    run_tri(2048, 512, 2048, 512, 4'b0001, 4'b0001, 30);
  endtask

  task automatic test_negative();
    run_tri(-1024, -1024, 0, 0, 4'b1000, 4'b1000, 60);
  endtask

  task automatic test_unaligned_and_bad_mode();
    run_tri(0, 0, 1000, 300, 4'b0010, 4'b0010, 70);
    run_tri(0, 0, 2048, 0, 4'b0011, 4'b0011, 71);
    run_tri(-128, 0, 128, 128, 4'b0001, 4'b0001, 72);
  endtask

  task automatic test_back_to_back();
    int na, nb;
    @(negedge clk);
    load(0, 0, 1024, 1024, 4'b1000, 50, na);
    valid_tri = 1'b1;
    @(negedge clk);
    load(-1024, 0, 0, 512, 4'b0100, 51, nb);
    for (int i = 0; i < na; i++) begin
      checks++;
      if (vsamp !== 1'b1 || halt !== 1'b0 || int'(tri_out[0][0]) !== 50) begin
        errors++;
        $display("FAIL b2b_first cycle=%0d: valid=%b halt=%b tri=%0d, required 1 0 50", i, vsamp, halt, int'(tri_out[0][0]));
      end
      @(negedge clk);
    end
    checks++;
    if (vsamp !== 1'b0 || halt !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: valid=%b halt=%b, required valid=0 halt=1", vsamp, halt);
    end
    @(negedge clk);
    valid_tri = 1'b0;
    for (int i = 0; i < nb; i++) begin
      checks++;
      if (vsamp !== 1'b1 || halt !== 1'b0 || int'(tri_out[0][0]) !== 51) begin
        errors++;
        $display("FAIL b2b_second cycle=%0d: valid=%b halt=%b tri=%0d, required 1 0 51", i, vsamp, halt, int'(tri_out[0][0]));
      end
      @(negedge clk);
    end
    checks++;
    if (vsamp !== 1'b0 || halt !== 1'b1 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_end: valid=%b halt=%b left=%0d, required valid=0 halt=1 left=0", vsamp, halt, q.size());
    end
    q.delete();
  endtask

  task automatic test_mid_reset();
    int n;
    @(negedge clk);
    load(0, 0, 1024, 1024, 4'b0100, 40, n);
    valid_tri = 1'b1;
    @(negedge clk);
    valid_tri = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (vsamp !== 1'b0 || halt !== 1'b1 || !outs_zero()) begin
      errors++;
      $display("FAIL mid_reset: valid=%b halt=%b zero=%b, required valid=0 halt=1 zero=1", vsamp, halt, outs_zero());
    end
    checks++;
    if (q.size() != n - 3) begin
      errors++;
      $display("FAIL mid_reset_count: left=%0d, required %0d", q.size(), n - 3);
    end
    q.delete();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (vsamp !== 1'b0 || halt !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: valid=%b halt=%b, required valid=0 halt=1", vsamp, halt);
    end
    run_tri(512, 256, 1536, 1280, 4'b1000, 4'b1000, 41);
  endtask

  initial begin
    for (int v = 0; v < 3; v++) begin
      col_in[v] = '0;
      for (int a = 0; a < 3; a++) tri_in[v][a] = '0;
    end
    box = '{default: '{default: '0}};
    test_reset();
    fork
      monitor();
    join_none
    test_basic();
    test_step_latch();
    test_degenerate();
    test_back_to_back();
    test_mid_reset();
    test_negative();
    test_unaligned_and_bad_mode();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
